ps2_byte_receiver: RTL and testbench

Receive-only PS/2 serial front end that feeds the mouse packet decoder. Inputs are the raw PS2_CLK and PS2_DAT pin levels, passed in as plain inputs after the top level's tri-state buffers. The block synchronises and deglitches the device clock, deserialises each 11-bit device-to-host frame, and checks the start bit, odd parity and stop bit. Every good byte is presented with a one-cycle `received_data_en` strobe, which is the interface the decoder counts packet bytes on.

---
 rtl/ps2_byte_receiver.sv | 121 ++++++++++++
 tb/tb_ps2_byte_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host receiver: syncs and deglitches the pins, deserialises 11-bit frames,
// and reports each good byte with a one-cycle strobe or each bad frame with an error pulse.
module ps2_byte_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       frame_error,
   output logic       busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FLT_FULL = FW'(FILTER_LEN);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic          r_fclk, r_fclk_d;
   logic [FW-1:0] r_flt_cnt;
   logic [TW-1:0] r_to_cnt;
   state_t        r_state;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_par;
   logic          w_sample;

   assign w_sample = r_fclk_d & ~r_fclk;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_dat_s1  <= 1'b1;
         r_dat_s2  <= 1'b1;
         r_fclk    <= 1'b1;
         r_fclk_d  <= 1'b1;
         r_flt_cnt <= '0;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_dat;
         r_dat_s2 <= r_dat_s1;
         r_fclk_d <= r_fclk;
         // a new level must persist FILTER_LEN counts before fclk follows it
         if (r_clk_s2 == r_fclk) begin
            r_flt_cnt <= '0;
         end else if (r_flt_cnt == FLT_FULL) begin
            r_fclk    <= r_clk_s2;
            r_flt_cnt <= '0;
         end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state          <= IDLE;
         r_bit_cnt        <= '0;
         r_shift          <= '0;
         r_par            <= 1'b0;
         r_to_cnt         <= '0;
         received_data    <= '0;
         received_data_en <= 1'b0;
         frame_error      <= 1'b0;
         busy             <= 1'b0;
      end else begin
         received_data_en <= 1'b0;
         frame_error      <= 1'b0;
         if (r_state == IDLE) begin
            r_to_cnt <= '0;
            if (w_sample && !r_dat_s2) begin
               r_state   <= DATA;
               r_bit_cnt <= '0;
               r_shift   <= '0;
               busy      <= 1'b1;
            end
         end else if (w_sample) begin
            // a bit arriving on the expiry cycle still counts
            r_to_cnt <= '0;
            case (r_state)
               DATA: begin
                  r_shift[r_bit_cnt] <= r_dat_s2;
                  if (r_bit_cnt == 3'd7) r_state <= PARITY;
                  else r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               PARITY: begin
                  r_par   <= r_dat_s2;
                  r_state <= STOP;
               end
               STOP: begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  if (r_dat_s2 && (^r_shift ^ r_par)) begin
                     received_data    <= r_shift;
                     received_data_en <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end else if (r_to_cnt == TO_LAST) begin
            frame_error <= 1'b1;
            r_state     <= IDLE;
            busy        <= 1'b0;
            r_to_cnt    <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Scoreboard bench: stimulus pushes the expected outcome of each frame, a monitor pops on every pulse.
module tb_ps2_byte_receiver;

   localparam int FL = 8;
   localparam int TO = 2000;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en, frame_error, busy;

   ps2_byte_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .received_data(received_data), .received_data_en(received_data_en),
      .frame_error(frame_error), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       err;
      logic [7:0] data;
      int         lat;
   } exp_t;

   exp_t       sb[$];
   int         nchecks = 0;
   int         nerrs   = 0;
   int         cyc     = 0;
   int         last_fall = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerrs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wcyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // pulse on the pin far shorter than the filter window
   task automatic glitch();
      ps2_clk = 1'b0;
      wcyc(3);
      ps2_clk = 1'b1;
      wcyc(20);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_before);
      for (int i = 0; i < nbits; i++) begin
         if (i == glitch_before) glitch();
         if (i == 2) chk("busy_mid", busy, 1);
         ps2_dat = bits[i];
         wcyc(25);
         ps2_clk   = 1'b0;
         last_fall = cyc;
         wcyc(50);
         ps2_clk = 1'b1;
         wcyc(25);
      end
      ps2_dat = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
      logic p;
      p = ~(^d) ^ pflip;
      return {stop, p, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                             input int glitch_before);
      exp_t e;
      e.lat = FL + 3;
      if (!pflip && stop) begin
         e.err = 1'b0; e.data = d; last_good = d;
      end else begin
         e.err = 1'b1; e.data = last_good;
      end
      sb.push_back(e);
      send_bits(mk_frame(d, pflip, stop), 11, glitch_before);
   endtask

   always @(negedge clock) begin
      if (resetn && (received_data_en || frame_error)) begin
         exp_t e;
         chk("exclusive", int'(received_data_en && frame_error), 0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {received_data_en, frame_error}, 0);
         end else begin
            e = sb.pop_front();
            chk("err_flag", frame_error, e.err);
            chk("data", received_data, e.data);
            chk("latency", cyc - (last_fall + 1), e.lat);
            chk("busy_at_result", busy, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      nchecks++; nerrs++;
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

   initial begin
      exp_t e;
      wcyc(5);
      chk("rst_data", received_data, 0);
      chk("rst_en", received_data_en, 0);
      chk("rst_err", frame_error, 0);
      chk("rst_busy", busy, 0);
      resetn = 1'b1;
      wcyc(50);

      send_frame(8'hF4, 1'b0, 1'b1, -1);
      wcyc(100);
      chk("busy_idle", busy, 0);
      send_frame(8'h08, 1'b1, 1'b1, -1);
      wcyc(100);
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      wcyc(100);

      e.err = 1'b1; e.data = last_good; e.lat = FL + 3 + TO;
      sb.push_back(e);
      send_bits(mk_frame(8'hA7, 1'b0, 1'b1), 5, -1);
      wcyc(TO + 200);
      chk("busy_after_timeout", busy, 0);
      send_frame(8'hFA, 1'b0, 1'b1, -1);
      wcyc(100);

      glitch();
      wcyc(50);
      send_frame(8'h55, 1'b0, 1'b1, 4);
      wcyc(100);

      send_frame(8'h09, 1'b0, 1'b1, -1);
      send_frame(8'h05, 1'b0, 1'b1, -1);
      send_frame(8'hFB, 1'b0, 1'b1, -1);
      wcyc(50);

      // reset in the high half of data bit 5: the partial frame must vanish silently
      send_bits(mk_frame(8'hC3, 1'b0, 1'b1), 7, -1);
      resetn = 1'b0;
      wcyc(1);
      chk("midrst_data", received_data, 0);
      chk("midrst_en", received_data_en, 0);
      chk("midrst_err", frame_error, 0);
      chk("midrst_busy", busy, 0);
      resetn = 1'b1;
      last_good = 8'h00;
      wcyc(300);
      send_frame(8'h08, 1'b0, 1'b1, -1);
      wcyc(100);

      for (int n = 0; n < 15; n++) begin
         logic [7:0] d;
         int kind, g;
         d    = 8'($urandom_range(0, 255));
         kind = int'($urandom_range(0, 3));
         g    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
         if ($urandom_range(0, 2) == 0) glitch();
         send_frame(d, kind == 2, kind != 3, g);
         wcyc(int'($urandom_range(0, 60)));
      end

      for (int w = 0; w < 500 && sb.size() != 0; w++) wcyc(1);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end

endmodule
